// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the MW stage of the 3-stage RISC-V pipeline.
// Optional CSR_MTIME_EN adds an internal 64-bit mtime/mtimecmp pair that drives MTIP.
module csr_trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            CSR_reg_rdMW,
  input  logic            CSR_reg_wrMW,
  input  logic            is_mretMW,
  input  logic            validMW,
  input  logic            stallMW,
  input  logic [XLEN-1:0] instMW,
  input  logic [XLEN-1:0] rs1_dataMW,
  input  logic [XLEN-1:0] pcMW,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] epc,
  output logic            epc_taken
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
`ifdef CSR_MTIME_EN
  localparam logic [11:0] ADDR_MTIME_LO    = 12'h7C0;
  localparam logic [11:0] ADDR_MTIME_HI    = 12'h7C1;
  localparam logic [11:0] ADDR_MTIMECMP_LO = 12'h7C2;
  localparam logic [11:0] ADDR_MTIMECMP_HI = 12'h7C3;
`endif

  logic [11:0]      csr_addr;
  logic [2:0]       funct3;
  logic             mstatus_mie, mstatus_mpie;
  logic             mie_mtie, mie_meie;
  logic [XLEN-1:0]  mtvec, mcause;
  logic [XLEN-1:2]  mepc;
  logic             ext_sync1, ext_sync2, mtip;
  logic             meip;
  logic [XLEN-1:0]  csr_val, op, wdata;
  logic             wr_req;
  logic             inst_go, irq_ext_hit, irq_tmr_hit, irq_pending;
  logic             irq_take, mret_take, csr_we;
  logic [3:0]       irq_cause;
  logic [XLEN-1:0]  trap_base, trap_vec, trap_mcause;
  logic             unused_bits;
`ifdef CSR_MTIME_EN
  logic [63:0]      mtime, mtimecmp;
`endif

  assign csr_addr = instMW[31:20];
  assign funct3   = instMW[14:12];
  assign meip     = ext_sync2;

`ifdef CSR_MTIME_EN
  assign unused_bits = ^{instMW[11:0], pcMW[1:0], timer_irq};
`else
  assign unused_bits = ^{instMW[11:0], pcMW[1:0]};
`endif

  always_comb begin
    csr_val = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_val[3] = mstatus_mie;
        csr_val[7] = mstatus_mpie;
      end
      ADDR_MIE: begin
        csr_val[7]  = mie_mtie;
        csr_val[11] = mie_meie;
      end
      ADDR_MTVEC:  csr_val = mtvec;
      ADDR_MEPC:   csr_val = {mepc, 2'b00};
      ADDR_MCAUSE: csr_val = mcause;
      ADDR_MIP: begin
        csr_val[7]  = mtip;
        csr_val[11] = meip;
      end
`ifdef CSR_MTIME_EN
      ADDR_MTIME_LO:    csr_val[31:0] = mtime[31:0];
      ADDR_MTIME_HI:    csr_val[31:0] = mtime[63:32];
      ADDR_MTIMECMP_LO: csr_val[31:0] = mtimecmp[31:0];
      ADDR_MTIMECMP_HI: csr_val[31:0] = mtimecmp[63:32];
`endif
      default: csr_val = '0;
    endcase
  end

  assign csr_rdata = CSR_reg_rdMW ? csr_val : '0;

  // Set/clear with a zero operand must not write, so wr_req tracks |op.
  always_comb begin
    op     = funct3[2] ? {{(XLEN-5){1'b0}}, instMW[19:15]} : rs1_dataMW;
    wdata  = csr_val;
    wr_req = 1'b0;
    case (funct3[1:0])
      2'b01: begin
        wdata  = op;
        wr_req = 1'b1;
      end
      2'b10: begin
        wdata  = csr_val | op;
        wr_req = |op;
      end
      2'b11: begin
        wdata  = csr_val & ~op;
        wr_req = |op;
      end
      default: wr_req = 1'b0;
    endcase
  end

  assign inst_go     = validMW & ~stallMW & ~reset;
  assign irq_ext_hit = mie_meie & meip;
  assign irq_tmr_hit = mie_mtie & mtip;
  assign irq_pending = mstatus_mie & (irq_ext_hit | irq_tmr_hit);
  assign irq_cause   = irq_ext_hit ? 4'd11 : 4'd7;
  // mret wins over a pending interrupt; the interrupt retries on the next valid instruction.
  assign irq_take    = irq_pending & inst_go & ~is_mretMW;
  assign mret_take   = is_mretMW & inst_go;
  assign csr_we      = CSR_reg_wrMW & inst_go & ~irq_take & wr_req;

  always_comb begin
    trap_base = {mtvec[XLEN-1:2], 2'b00};
    trap_vec  = (mtvec[1:0] == 2'b01)
              ? trap_base + {{(XLEN-6){1'b0}}, irq_cause, 2'b00}
              : trap_base;
    trap_mcause           = '0;
    trap_mcause[XLEN-1]   = 1'b1;
    trap_mcause[3:0]      = irq_cause;
  end

  always_comb begin
    epc_taken = 1'b0;
    epc       = '0;
    if (irq_take) begin
      epc_taken = 1'b1;
      epc       = trap_vec;
    end else if (mret_take) begin
      epc_taken = 1'b1;
      epc       = {mepc, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mepc         <= '0;
      mcause       <= '0;
      ext_sync1    <= 1'b0;
      ext_sync2    <= 1'b0;
      mtip         <= 1'b0;
`ifdef CSR_MTIME_EN
      mtime        <= '0;
      mtimecmp     <= '1;
`endif
    end else begin
      ext_sync1 <= ext_irq;
      ext_sync2 <= ext_sync1;
`ifdef CSR_MTIME_EN
      mtime <= mtime + 64'd1;
      mtip  <= (mtime >= mtimecmp);
`else
      mtip  <= timer_irq;
`endif
      if (csr_we) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= wdata[3];
            mstatus_mpie <= wdata[7];
          end
          ADDR_MIE: begin
            mie_mtie <= wdata[7];
            mie_meie <= wdata[11];
          end
          ADDR_MTVEC:  mtvec  <= wdata;
          ADDR_MEPC:   mepc   <= wdata[XLEN-1:2];
          ADDR_MCAUSE: mcause <= wdata;
`ifdef CSR_MTIME_EN
          ADDR_MTIMECMP_LO: mtimecmp[31:0]  <= wdata[31:0];
          ADDR_MTIMECMP_HI: mtimecmp[63:32] <= wdata[31:0];
`endif
          default: ;
        endcase
      end
      if (irq_take) begin
        mepc         <= pcMW[XLEN-1:2];
        mcause       <= trap_mcause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_take) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

endmodule
